// File: rtl/munoc_monitor_pkg.sv
// Shared constants for the munoc monitor blocks: width and bit positions of
// the per-channel sticky error vector.
package munoc_monitor_pkg;

  localparam int BW_ERR        = 3;
  localparam int ERR_UNDERFLOW = 0;
  localparam int ERR_OVERFLOW  = 1;
  localparam int ERR_TIMEOUT   = 2;

endpackage

// File: rtl/munoc_pending_monitor_if.sv
// Transaction/status bundle between a traffic source (master) and the
// pending-transaction monitor (slave).
interface munoc_pending_monitor_if #(
  parameter int NUM_CH   = 4,
  parameter int BW_COUNT = 4
);

  logic [NUM_CH-1:0]                          inc;
  logic [NUM_CH-1:0]                          dec;
  logic [NUM_CH*BW_COUNT-1:0]                 count;
  logic [NUM_CH-1:0]                          idle;
  logic                                       all_idle;
  logic [NUM_CH*munoc_monitor_pkg::BW_ERR-1:0] err_flag;
  logic                                       error;

  modport master (
    output inc, dec,
    input  count, idle, all_idle, err_flag, error
  );

  modport slave (
    input  inc, dec,
    output count, idle, all_idle, err_flag, error
  );

endinterface

// File: rtl/munoc_pending_channel.sv
// One tracked channel: saturating outstanding counter, sticky error flags and,
// when MUNOC_PENDING_MONITOR_TIMEOUT_EN is defined, a stall timer.
module munoc_pending_channel
  import munoc_monitor_pkg::*;
#(
`ifdef MUNOC_PENDING_MONITOR_TIMEOUT_EN
  parameter int TIMEOUT  = 500,
  parameter int BW_TIMER = 16,
`endif
  parameter int BW_COUNT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                clear,
  input  logic                inc,
  input  logic                dec,
  output logic [BW_COUNT-1:0] count,
  output logic [BW_ERR-1:0]   err_flag
);

  localparam logic [BW_COUNT-1:0] CNT_MAX = '1;

  logic inc_only, dec_only;
  logic underflow, overflow;
  logic udf_q, ovf_q, timeout;

  assign inc_only  = inc & ~dec;
  assign dec_only  = dec & ~inc;
  assign underflow = enable & dec_only & (count == '0);
  assign overflow  = enable & inc_only & (count == CNT_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      if (inc_only && count != CNT_MAX)
        count <= count + BW_COUNT'(1);
      else if (dec_only && count != '0)
        count <= count - BW_COUNT'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      udf_q <= 1'b0;
      ovf_q <= 1'b0;
    end else if (clear) begin
      udf_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      if (underflow) udf_q <= 1'b1;
      if (overflow)  ovf_q <= 1'b1;
    end
  end

`ifdef MUNOC_PENDING_MONITOR_TIMEOUT_EN
  localparam logic [BW_TIMER-1:0] TIMER_LAST = BW_TIMER'(TIMEOUT - 1);

  logic [BW_TIMER-1:0] timer;
  logic                stall;
  logic                to_q;

  // The timer parks at TIMEOUT-1; the next stall edge raises the flag.
  assign stall = (count != '0) & ~inc & ~dec;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer <= '0;
      to_q  <= 1'b0;
    end else if (clear) begin
      timer <= '0;
      to_q  <= 1'b0;
    end else if (enable) begin
      if (!stall)
        timer <= '0;
      else if (timer == TIMER_LAST)
        to_q <= 1'b1;
      else
        timer <= timer + BW_TIMER'(1);
    end
  end

  assign timeout = to_q;
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    err_flag                = '0;
    err_flag[ERR_UNDERFLOW] = udf_q;
    err_flag[ERR_OVERFLOW]  = ovf_q;
    err_flag[ERR_TIMEOUT]   = timeout;
  end

endmodule

// File: rtl/munoc_pending_monitor.sv
// Per-channel outstanding-transaction monitor with idle/error summaries.
// Stall timeout detection is built only when MUNOC_PENDING_MONITOR_TIMEOUT_EN is defined.
module munoc_pending_monitor
  import munoc_monitor_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int BW_COUNT = 4,
  parameter int TIMEOUT  = 500,
  parameter int BW_TIMER = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   clear,
  munoc_pending_monitor_if.slave mon
);

  if (NUM_CH < 1 || NUM_CH > 32 || BW_COUNT < 1 || BW_TIMER < 1 || BW_TIMER > 62 ||
      TIMEOUT < 2 || longint'(TIMEOUT) >= (longint'(1) << BW_TIMER)) begin : g_param_check
    $error("munoc_pending_monitor: illegal parameter combination");
  end

  logic [NUM_CH*BW_COUNT-1:0] count_w;
  logic [NUM_CH*BW_ERR-1:0]   err_w;
  logic [NUM_CH-1:0]          idle_w;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    munoc_pending_channel #(
`ifdef MUNOC_PENDING_MONITOR_TIMEOUT_EN
      .TIMEOUT  (TIMEOUT),
      .BW_TIMER (BW_TIMER),
`endif
      .BW_COUNT (BW_COUNT)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .enable   (enable),
      .clear    (clear),
      .inc      (mon.inc[c]),
      .dec      (mon.dec[c]),
      .count    (count_w[c*BW_COUNT +: BW_COUNT]),
      .err_flag (err_w[c*BW_ERR +: BW_ERR])
    );

    assign idle_w[c] = (count_w[c*BW_COUNT +: BW_COUNT] == '0);
  end

  // Summaries are decoded straight from the channel registers.
  assign mon.count    = count_w;
  assign mon.err_flag = err_w;
  assign mon.idle     = idle_w;
  assign mon.all_idle = &idle_w;
  assign mon.error    = |err_w;

endmodule

// File: tb/tb_munoc_pending_monitor.sv
// Self-checking bench for munoc_pending_monitor: vector table, directed corner
// sequences and randomized traffic against a behavioural model.
module tb_munoc_pending_monitor;
  import munoc_monitor_pkg::*;

  localparam int NUM_CH   = 4;
  localparam int BW_COUNT = 4;
  localparam int TIMEOUT  = 8;
  localparam int BW_TIMER = 4;
  localparam int CNT_MAX  = (1 << BW_COUNT) - 1;
`ifdef MUNOC_PENDING_MONITOR_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, enable, clear;

  munoc_pending_monitor_if #(.NUM_CH(NUM_CH), .BW_COUNT(BW_COUNT)) mon ();

  munoc_pending_monitor #(
    .NUM_CH(NUM_CH), .BW_COUNT(BW_COUNT), .TIMEOUT(TIMEOUT), .BW_TIMER(BW_TIMER)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .clear(clear), .mon(mon)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model: counts, length of the current stall run, sticky flags.
  int m_cnt[NUM_CH];
  int m_run[NUM_CH];
  bit m_udf[NUM_CH];
  bit m_ovf[NUM_CH];
  bit m_to[NUM_CH];

  typedef struct {
    logic [3:0]  inc;
    logic [3:0]  dec;
    logic        en;
    logic        cl;
    logic [15:0] count;
    logic [11:0] err;
  } vec_t;

  vec_t tbl[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_cnt[c] = 0; m_run[c] = 0; m_udf[c] = 0; m_ovf[c] = 0; m_to[c] = 0;
    end
  endtask

  task automatic model_step(input logic [NUM_CH-1:0] i, input logic [NUM_CH-1:0] d,
                            input logic en, input logic cl);
    for (int c = 0; c < NUM_CH; c++) begin
      if (cl) begin
        m_cnt[c] = 0; m_run[c] = 0; m_udf[c] = 0; m_ovf[c] = 0; m_to[c] = 0;
      end else if (en) begin
        if (m_cnt[c] != 0 && !i[c] && !d[c]) begin
          m_run[c]++;
          if (TO_EN && m_run[c] >= TIMEOUT) m_to[c] = 1;
        end else begin
          m_run[c] = 0;
        end
        if (i[c] && !d[c]) begin
          if (m_cnt[c] == CNT_MAX) m_ovf[c] = 1;
          else m_cnt[c]++;
        end else if (d[c] && !i[c]) begin
          if (m_cnt[c] == 0) m_udf[c] = 1;
          else m_cnt[c]--;
        end
      end
    end
  endtask

  task automatic check_model(input string tag);
    logic [15:0] ec;
    logic [11:0] ee;
    logic [3:0]  ei;
    for (int c = 0; c < NUM_CH; c++) begin
      ec[c*BW_COUNT +: BW_COUNT]  = BW_COUNT'(m_cnt[c]);
      ei[c]                       = (m_cnt[c] == 0);
      ee[c*BW_ERR + ERR_UNDERFLOW] = m_udf[c];
      ee[c*BW_ERR + ERR_OVERFLOW]  = m_ovf[c];
      ee[c*BW_ERR + ERR_TIMEOUT]   = m_to[c];
    end
    chk({tag, " count"},    32'(mon.count),    32'(ec));
    chk({tag, " idle"},     32'(mon.idle),     32'(ei));
    chk({tag, " all_idle"}, 32'(mon.all_idle), 32'(&ei));
    chk({tag, " err_flag"}, 32'(mon.err_flag), 32'(ee));
    chk({tag, " error"},    32'(mon.error),    32'(|ee));
  endtask

  task automatic cycle(input logic [NUM_CH-1:0] i, input logic [NUM_CH-1:0] d,
                       input logic en, input logic cl);
    mon.inc = i; mon.dec = d; enable = en; clear = cl;
    @(posedge clk);
    model_step(i, d, en, cl);
    #1;
  endtask

  function automatic logic [31:0] cnt_of(input int c);
    return 32'(mon.count[c*BW_COUNT +: BW_COUNT]);
  endfunction

  function automatic logic [31:0] flag_of(input int c, input int b);
    return 32'(mon.err_flag[c*BW_ERR + b]);
  endfunction

  initial begin
    tbl[0]  = '{4'b0010, 4'b0000, 1'b1, 1'b0, 16'h0010, 12'h000};
    tbl[1]  = '{4'b0010, 4'b0000, 1'b1, 1'b0, 16'h0020, 12'h000};
    tbl[2]  = '{4'b0010, 4'b0000, 1'b1, 1'b0, 16'h0030, 12'h000};
    tbl[3]  = '{4'b0000, 4'b0010, 1'b1, 1'b0, 16'h0020, 12'h000};
    tbl[4]  = '{4'b0000, 4'b0010, 1'b1, 1'b0, 16'h0010, 12'h000};
    tbl[5]  = '{4'b0000, 4'b0010, 1'b1, 1'b0, 16'h0000, 12'h000};
    tbl[6]  = '{4'b0000, 4'b0001, 1'b1, 1'b0, 16'h0000, 12'h001};
    tbl[7]  = '{4'b0001, 4'b0000, 1'b1, 1'b0, 16'h0001, 12'h001};
    tbl[8]  = '{4'b0000, 4'b0001, 1'b1, 1'b0, 16'h0000, 12'h001};
    tbl[9]  = '{4'b0001, 4'b0000, 1'b0, 1'b0, 16'h0000, 12'h001};
    tbl[10] = '{4'b0000, 4'b0000, 1'b0, 1'b1, 16'h0000, 12'h000};
    tbl[11] = '{4'b1111, 4'b0000, 1'b1, 1'b0, 16'h1111, 12'h000};
    tbl[12] = '{4'b0101, 4'b0101, 1'b1, 1'b0, 16'h1111, 12'h000};
    tbl[13] = '{4'b0000, 4'b1111, 1'b1, 1'b0, 16'h0000, 12'h000};
    tbl[14] = '{4'b0010, 4'b0001, 1'b1, 1'b0, 16'h0010, 12'h001};

    // Reset state
    rst = 1'b1; enable = 1'b0; clear = 1'b0; mon.inc = '0; mon.dec = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check_model("reset");

    // Vector table
    for (int k = 0; k < 15; k++) begin
      logic [3:0] exp_idle;
      cycle(tbl[k].inc, tbl[k].dec, tbl[k].en, tbl[k].cl);
      for (int c = 0; c < NUM_CH; c++) exp_idle[c] = (tbl[k].count[c*4 +: 4] == 4'd0);
      chk($sformatf("vec%0d count", k), 32'(mon.count),    32'(tbl[k].count));
      chk($sformatf("vec%0d err", k),   32'(mon.err_flag), 32'(tbl[k].err));
      chk($sformatf("vec%0d error", k), 32'(mon.error),    32'(|tbl[k].err));
      chk($sformatf("vec%0d idle", k),  32'(mon.idle),     32'(exp_idle));
    end
    cycle('0, '0, 1'b0, 1'b1);
    check_model("post-table clear");

    // Saturation on ch2
    for (int k = 1; k <= 16; k++) begin
      cycle(4'b0100, 4'b0000, 1'b1, 1'b0);
      if (k == 15) begin
        chk("sat cnt after 15", cnt_of(2), 32'd15);
        chk("sat ovf after 15", flag_of(2, ERR_OVERFLOW), 32'd0);
      end
      if (k == 16) begin
        chk("sat cnt after 16", cnt_of(2), 32'd15);
        chk("sat ovf after 16", flag_of(2, ERR_OVERFLOW), 32'd1);
      end
    end
    cycle('0, '0, 1'b1, 1'b0);
    chk("sat ovf sticky", flag_of(2, ERR_OVERFLOW), 32'd1);
    cycle('0, '0, 1'b0, 1'b1);

    // Stall timeout on ch3
    cycle(4'b1000, 4'b0000, 1'b1, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      cycle('0, '0, 1'b1, 1'b0);
      if (k == 7) chk("to after E7", flag_of(3, ERR_TIMEOUT), 32'd0);
      if (k == 8) chk("to after E8", flag_of(3, ERR_TIMEOUT), 32'(TO_EN));
    end
    check_model("timeout basic");
    cycle('0, '0, 1'b1, 1'b1);

    // A dec mid-stall restarts the run
    cycle(4'b1000, 4'b0000, 1'b1, 1'b0);
    cycle(4'b1000, 4'b0000, 1'b1, 1'b0);
    for (int k = 1; k <= 12; k++) begin
      cycle('0, (k == 4) ? 4'b1000 : 4'b0000, 1'b1, 1'b0);
      if (k == 11) chk("to restart E11", flag_of(3, ERR_TIMEOUT), 32'd0);
      if (k == 12) chk("to restart E12", flag_of(3, ERR_TIMEOUT), 32'(TO_EN));
    end
    chk("to restart cnt", cnt_of(3), 32'd1);
    cycle('0, '0, 1'b0, 1'b1);

    // Simultaneous inc/dec with enable gaps, then timer freeze
    cycle(4'b0001, 4'b0000, 1'b1, 1'b0);
    for (int k = 0; k < 20; k++)
      cycle(4'b0001, 4'b0001, !(k >= 5 && k < 10), 1'b0);
    chk("both cnt", cnt_of(0), 32'd1);
    chk("both err", 32'(mon.err_flag), 32'd0);
    repeat (4) cycle('0, '0, 1'b1, 1'b0);
    repeat (5) cycle('0, '0, 1'b0, 1'b0);
    repeat (3) cycle('0, '0, 1'b1, 1'b0);
    chk("freeze to after 7", flag_of(0, ERR_TIMEOUT), 32'd0);
    cycle('0, '0, 1'b1, 1'b0);
    chk("freeze to after 8", flag_of(0, ERR_TIMEOUT), 32'(TO_EN));
    check_model("freeze");
    cycle('0, '0, 1'b1, 1'b1);

    // Asynchronous reset mid-operation
    repeat (5) cycle(4'b0001, 4'b0000, 1'b1, 1'b0);
    cycle(4'b0000, 4'b0010, 1'b1, 1'b0);
    chk("pre-rst cnt0", cnt_of(0), 32'd5);
    chk("pre-rst error", 32'(mon.error), 32'd1);
    mon.inc = '0; mon.dec = '0;
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_model("async rst");
    @(posedge clk);
    #1 rst = 1'b0;
    check_model("after rst");

    // clear while disabled
    repeat (5) cycle(4'b0100, 4'b0000, 1'b1, 1'b0);
    cycle(4'b0000, 4'b1000, 1'b1, 1'b0);
    cycle('0, '0, 1'b0, 1'b1);
    chk("clr all_idle", 32'(mon.all_idle), 32'd1);
    chk("clr error", 32'(mon.error), 32'd0);
    check_model("clear disabled");

    // Randomized traffic
    for (int k = 0; k < 600; k++) begin
      logic [3:0] ri, rd;
      int p;
      p = ((k / 60) % 2 == 0) ? 35 : 6;
      for (int c = 0; c < NUM_CH; c++) begin
        ri[c] = ($urandom_range(0, 99) < p);
        rd[c] = ($urandom_range(0, 99) < p);
      end
      cycle(ri, rd, $urandom_range(0, 9) != 0, $urandom_range(0, 249) == 0);
      check_model($sformatf("rand%0d", k));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/munoc_pending_monitor.md
MUNOC_PENDING_MONITOR -- requirements
Module: munoc_pending_monitor

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of independently tracked channels (1..32).
REQ-002 SHALL have parameter BW_COUNT, default 4: width of each channel's outstanding counter.
REQ-003 SHALL have parameter TIMEOUT, default 500: consecutive stalled cycles before a channel's timeout is flagged (>=2).
REQ-004 SHALL have parameter BW_TIMER, default 16: stall timer width; TIMEOUT SHALL be < 2**BW_TIMER.
REQ-005 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port enable  input  1  when low, all state is frozen.
REQ-008 SHALL have port clear  input  1  synchronous clear of counters, timers and sticky flags.
REQ-009 SHALL have port inc  input  NUM_CH  per-channel transaction issued.
REQ-010 SHALL have port dec  input  NUM_CH  per-channel transaction completed.
REQ-011 SHALL have port count  output  NUM_CH*BW_COUNT  channel counters, channel c at bits [c*BW_COUNT +: BW_COUNT].
REQ-012 SHALL have port idle  output  NUM_CH  per channel, count==0.
REQ-013 SHALL have port all_idle  output  1  AND of idle.
REQ-014 SHALL have port err_flag  output  NUM_CH*BW_ERR  per-channel sticky error bits (underflow, overflow, timeout).
REQ-015 SHALL have port error  output  1  OR of all err_flag bits.

Function
REQ-016 Each channel counter SHALL update on an enabled edge: inc only -> +1, dec only -> -1, both or neither -> unchanged.
REQ-017 dec-only at count==0 SHALL leave count at 0 and set that channel's underflow flag.
REQ-018 inc-only at count==2**BW_COUNT-1 SHALL saturate and set that channel's overflow flag.
REQ-019 A stall edge SHALL be an enabled edge where count!=0 and neither inc nor dec is high for that channel.
REQ-020 The stall timer SHALL increment on each stall edge, reset to 0 on any enabled edge that is not a stall edge, and saturate at TIMEOUT-1.
REQ-021 The timeout flag SHALL set on the stall edge at which the timer already equals TIMEOUT-1 (the TIMEOUT-th consecutive stall edge).
REQ-022 All error flags SHALL be sticky until clear or rst; later activity SHALL NOT clear them.
REQ-023 clear SHALL take priority over inc/dec and act even when enable is low.
REQ-024 count SHALL be registered; idle, all_idle and error SHALL be combinational from registers (zero added latency).
REQ-025 Channels SHALL be fully independent; events on one channel SHALL NOT affect another.

Reset
REQ-026 On rst: every count=0, every timer=0, every err_flag=0; hence idle all-ones, all_idle=1, error=0.
REQ-027 rst asserted mid-operation SHALL abort all tracking immediately; no flag survives reset.

Configuration
REQ-028 With macro MUNOC_PENDING_MONITOR_TIMEOUT_EN defined, stall timers and timeout flags SHALL be implemented per REQ-019..021.
REQ-029 Without MUNOC_PENDING_MONITOR_TIMEOUT_EN, no timer logic SHALL be synthesised, timeout flags SHALL read constant 0, and BW_TIMER/TIMEOUT SHALL be ignored.

Structure
REQ-030 Shared package munoc_monitor_pkg SHALL hold BW_ERR=3 and bit indices ERR_UNDERFLOW=0, ERR_OVERFLOW=1, ERR_TIMEOUT=2.
REQ-031 Per-channel logic SHALL be sub-module munoc_pending_channel (counter, timer, sticky flags), generated NUM_CH times.

Verification
REQ-032 NUM_CH=4, BW_COUNT=4: 3 inc on ch1 then 3 dec -> count1 goes 1,2,3,2,1,0; idle[1] low for exactly 5 edges; err_flag all 0.
REQ-033 dec on ch0 at count 0 -> count0 stays 0, underflow flag of ch0 =1, error=1; persists through later inc/dec until clear.
REQ-034 16 inc on ch2 (BW_COUNT=4) -> count2 saturates at 15 after the 15th, overflow flag set after the 16th.
REQ-035 TIMEOUT=8, macro on: inc ch3 at edge E0, then quiet -> timeout flag of ch3 visible after E8, not after E7; same with one dec at E4 restarts the count (flag after E12 if count still nonzero).
REQ-036 inc and dec simultaneously on ch0 for 20 edges at count 1 with enable low for 5 of them -> count stays 1, no timeout, no flags; enable low freezes timer.
REQ-037 rst pulsed with count=5 and flags set, and separately clear with enable=0 -> all counts 0, all_idle=1, error=0 on next observation.
